// File: rtl/mem_lsu_pkg.sv
// Shared types, funct3 codes and byte-lane helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Naturally aligned byte offset for the access size; reserved codes behave as W.
    function automatic logic [1:0] nat_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return a;
            F3_H, F3_HU: return {a[1], 1'b0};
            default:     return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return nat_off(f3, a) != a;
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << off;
            F3_H, F3_HU: return 4'b0011 << {off[1], 1'b0};
            default:     return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] rep_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B, F3_BU: return {4{d[7:0]}};
            F3_H, F3_HU: return {2{d[15:0]}};
            default:     return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_ld_align.sv
// Combinational load lane select and sign/zero extension of the returned memory word.
module lsu_ld_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (i_off)
            2'd0:    byte_v = i_rdata[7:0];
            2'd1:    byte_v = i_rdata[15:8];
            2'd2:    byte_v = i_rdata[23:16];
            default: byte_v = i_rdata[31:24];
        endcase
        half_v = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   o_data = {24'h000000, byte_v};
            F3_H:    o_data = {{16{half_v[15]}}, half_v};
            F3_HU:   o_data = {16'h0000, half_v};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake with pipeline stall and ack timeout.
// Define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic          i_rd_en,
    input  logic          i_wr_en,
    input  logic [2:0]    i_funct3,
    input  logic [AW-1:0] i_addrM,
    input  logic [DW-1:0] i_st_dataM,
    output logic          o_stall,
    output logic [DW-1:0] o_ld_dataM,
    output logic          o_ld_valid,
    output logic          o_misalign,
    output logic          o_bus_err,
    output logic          o_dmem_req,
    output logic          o_dmem_we,
    output logic [AW-1:0] o_dmem_addr,
    output logic [3:0]    o_dmem_be,
    output logic [DW-1:0] o_dmem_wdata,
    input  logic          i_dmem_ack,
    input  logic [DW-1:0] i_dmem_rdata
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    lsu_state_e    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    off_q, off_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          bus_err_q, bus_err_d;
    logic          misalign_d;

    logic          mem_op;
    logic          trap;
    logic [1:0]    off_in;
    logic [DW-1:0] ld_ext;

    lsu_ld_align u_ld_align (
        .i_rdata  (i_dmem_rdata),
        .i_off    (off_q),
        .i_funct3 (f3_q),
        .o_data   (ld_ext)
    );

    always_comb begin
        mem_op = i_valid & (i_rd_en | i_wr_en);
        off_in = nat_off(i_funct3, i_addrM[1:0]);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap   = is_misaligned(i_funct3, i_addrM[1:0]);
`else
        trap   = 1'b0;
`endif

        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        off_d      = off_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        f3_d       = f3_q;
        ld_data_d  = ld_data_q;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        o_stall    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d      = 16'd0;
                misalign_d = mem_op & trap;
                if (mem_op && !trap) begin
                    // A simultaneous rd/wr is resolved as a store.
                    addr_d    = {i_addrM[AW-1:2], 2'b00};
                    off_d     = off_in;
                    be_d      = calc_be(i_funct3, off_in);
                    wdata_d   = rep_wdata(i_funct3, i_st_dataM);
                    we_d      = i_wr_en;
                    f3_d      = i_funct3;
                    ld_data_d = '0;
                    o_stall   = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (i_dmem_ack) begin
                    if (!we_q) ld_data_d = ld_ext;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    bus_err_d = 1'b1;
                    ld_data_d = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            addr_q    <= '0;
            off_q     <= 2'b00;
            be_q      <= 4'h0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            ld_data_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            off_q     <= off_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            ld_data_q <= ld_data_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign o_misalign = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_d;
    assign o_misalign      = 1'b0;
`endif

    // Bus fields are only presented while the request is live.
    assign o_dmem_req   = (state_q == BUSY);
    assign o_dmem_we    = o_dmem_req & we_q;
    assign o_dmem_addr  = o_dmem_req ? addr_q  : '0;
    assign o_dmem_be    = o_dmem_req ? be_q    : 4'h0;
    assign o_dmem_wdata = o_dmem_req ? wdata_q : '0;
    assign o_ld_valid   = (state_q == DONE) & ~we_q;
    assign o_ld_dataM   = ld_data_q;
    assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed, table-driven bench for mem_lsu (built with TIMEOUT_CYC=4).
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, rd_en, wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data;
    logic        stall, ld_valid, misalign, bus_err;
    logic [31:0] ld_data;
    logic        req, we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        ack;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_lsu #(.DW(32), .AW(32), .TIMEOUT_CYC(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_rd_en      (rd_en),
        .i_wr_en      (wr_en),
        .i_funct3     (funct3),
        .i_addrM      (addr),
        .i_st_dataM   (st_data),
        .o_stall      (stall),
        .o_ld_dataM   (ld_data),
        .o_ld_valid   (ld_valid),
        .o_misalign   (misalign),
        .o_bus_err    (bus_err),
        .o_dmem_req   (req),
        .o_dmem_we    (we),
        .o_dmem_addr  (dm_addr),
        .o_dmem_be    (dm_be),
        .o_dmem_wdata (dm_wdata),
        .i_dmem_ack   (ack),
        .i_dmem_rdata (dm_rdata)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; rd_en = 0; wr_en = 0; funct3 = 3'b000;
        addr = 0; st_data = 0; ack = 0; dm_rdata = 0;
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] sd);
        valid = 1; rd_en = rd; wr_en = wr; funct3 = f3; addr = a; st_data = sd;
    endtask

    // One memory op with ack in the first BUSY cycle; entered and left at posedge+1 in IDLE.
    task automatic run_vec(input vec_t v);
        logic is_st;
        is_st = v.wr;
        drive_op(v.f3, v.rd, v.wr, v.a, v.sd);
        @(negedge clk);
        chk({v.name, " stall_idle"}, 32'(stall), 32'd1);
        chk({v.name, " req_idle"},   32'(req),   32'd0);
        tick();
        @(negedge clk);
        chk({v.name, " req_busy"},   32'(req),   32'd1);
        chk({v.name, " stall_busy"}, 32'(stall), 32'd1);
        chk({v.name, " we"},         32'(we),    32'(is_st));
        chk({v.name, " addr"},       dm_addr,    v.exp_addr);
        chk({v.name, " be"},         32'(dm_be), 32'(v.exp_be));
        if (is_st) chk({v.name, " wdata"}, dm_wdata, v.exp_wdata);
        ack = 1; dm_rdata = v.rdata;
        tick();
        ack = 0; dm_rdata = 0;
        @(negedge clk);
        chk({v.name, " stall_done"}, 32'(stall),    32'd0);
        chk({v.name, " req_done"},   32'(req),      32'd0);
        chk({v.name, " ld_valid"},   32'(ld_valid), 32'(!is_st));
        if (!is_st) chk({v.name, " ld_data"}, ld_data, v.exp_ld);
        tick();
        idle_inputs();
        @(negedge clk);
        chk({v.name, " ld_valid_after"}, 32'(ld_valid), 32'd0);
        chk({v.name, " stall_after"},    32'(stall),    32'd0);
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;

        vecs[0] = '{"LW",     3'b010, 1, 0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{"LB",     3'b000, 1, 0, 32'h103, 32'h0,        32'h80112233, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80};
        vecs[2] = '{"LBU",    3'b100, 1, 0, 32'h103, 32'h0,        32'h80112233, 32'h100, 4'h8, 32'h0,        32'h00000080};
        vecs[3] = '{"SH",     3'b001, 0, 1, 32'h202, 32'h0000ABCD, 32'h0,        32'h200, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[4] = '{"LH",     3'b001, 1, 0, 32'h102, 32'h0,        32'h80011234, 32'h100, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[5] = '{"LHU",    3'b101, 1, 0, 32'h100, 32'h0,        32'h1234F00D, 32'h100, 4'h3, 32'h0,        32'h0000F00D};
        vecs[6] = '{"SB",     3'b000, 0, 1, 32'h301, 32'h1234565A, 32'h0,        32'h300, 4'h2, 32'h5A5A5A5A, 32'h0};
        vecs[7] = '{"SW",     3'b010, 0, 1, 32'h400, 32'h12345678, 32'h0,        32'h400, 4'hF, 32'h12345678, 32'h0};
        vecs[8] = '{"LRSV",   3'b011, 1, 0, 32'h010, 32'h0,        32'hCAFEF00D, 32'h010, 4'hF, 32'h0,        32'hCAFEF00D};
        vecs[9] = '{"RDWR",   3'b010, 1, 1, 32'h504, 32'h0BADF00D, 32'h11111111, 32'h504, 4'hF, 32'h0BADF00D, 32'h0};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst stall",    32'(stall),    32'd0);
        chk("rst req",      32'(req),      32'd0);
        chk("rst ld_valid", 32'(ld_valid), 32'd0);
        chk("rst ld_data",  ld_data,       32'd0);
        chk("rst bus_err",  32'(bus_err),  32'd0);
        chk("rst misalign", 32'(misalign), 32'd0);
        chk("rst be",       32'(dm_be),    32'd0);
        chk("rst addr",     dm_addr,       32'd0);
        tick();
        rst = 0;
        tick();

        // Non-memory instruction passes through
        valid = 1;
        @(negedge clk);
        chk("nonmem stall", 32'(stall), 32'd0);
        tick();
        @(negedge clk);
        chk("nonmem req", 32'(req), 32'd0);
        tick();
        idle_inputs();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Misaligned LW
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        drive_op(3'b010, 1, 0, 32'h101, 32'h0);
        @(negedge clk);
        chk("mis stall", 32'(stall),    32'd0);
        chk("mis req",   32'(req),      32'd0);
        chk("mis pulse_early", 32'(misalign), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("mis pulse", 32'(misalign), 32'd1);
        chk("mis req2",  32'(req),      32'd0);
        tick();
        @(negedge clk);
        chk("mis pulse_end", 32'(misalign), 32'd0);
        tick();
`else
        run_vec('{"LWMIS", 3'b010, 1, 0, 32'h101, 32'h0, 32'h76543210, 32'h100, 4'hF, 32'h0, 32'h76543210});
        run_vec('{"LHMIS", 3'b101, 1, 0, 32'h103, 32'h0, 32'hBEEF0000, 32'h100, 4'hC, 32'h0, 32'h0000BEEF});
        chk("mis tied", 32'(misalign), 32'd0);
`endif

        // Ack withheld: timeout after 4 BUSY cycles
        drive_op(3'b010, 1, 0, 32'h040, 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("tmo req",     32'(req),     32'd1);
            chk("tmo bus_err", 32'(bus_err), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("tmo bus_err_pulse", 32'(bus_err),  32'd1);
        chk("tmo stall_done",    32'(stall),    32'd0);
        chk("tmo ld_valid",      32'(ld_valid), 32'd1);
        chk("tmo ld_data",       ld_data,       32'd0);
        chk("tmo req_done",      32'(req),      32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("tmo bus_err_end", 32'(bus_err), 32'd0);
        tick();

        // Reset in BUSY, late ack ignored
        drive_op(3'b010, 1, 0, 32'h080, 32'h0);
        tick();
        @(negedge clk);
        chk("rbusy req", 32'(req), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        chk("rbusy req_drop", 32'(req),   32'd0);
        chk("rbusy stall",    32'(stall), 32'd0);
        tick();
        ack = 1; dm_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("rbusy late_ack_req", 32'(req), 32'd0);
        tick();
        ack = 0; dm_rdata = 0;
        @(negedge clk);
        chk("rbusy ld_valid",  32'(ld_valid), 32'd0);
        chk("rbusy req_after", 32'(req),      32'd0);
        tick();
        @(negedge clk);
        chk("rbusy ld_valid2", 32'(ld_valid), 32'd0);
        chk("rbusy ld_data",   ld_data,       32'd0);

        // Fresh op after the aborted one proves the FSM is back in IDLE
        tick();
        run_vec('{"LWPOST", 3'b010, 1, 0, 32'h0C0, 32'h0, 32'h01234567, 32'h0C0, 4'hF, 32'h0, 32'h01234567});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
